// File: rtl/unpacker_tx.sv
// rtl/unpacker_tx.sv - word-to-UART serializer fed from a registered-read FIFO
//
// Pulls one WORD_WIDTH word at a time from an upstream FIFO and transmits it
// as NUM_BYTES back-to-back UART frames, least significant byte first and
// least significant bit first within each byte.
//
// Optional feature macro: UNPACKER_PARITY_EN
//    defined   : 11-bit frame (start, data, even parity, stop)
//    undefined : 10-bit frame (start, data, stop)
//
// Ports:
//    clk        - single clock for all logic
//    rst        - asynchronous, active-high reset
//    word_in    - word presented by the upstream FIFO one cycle after word_ren
//    word_empty - upstream FIFO empty flag, only looked at while idle
//    word_ren   - one-cycle read strobe to the upstream FIFO
//    tx         - UART serial line, idle high
//    busy       - high whenever the serializer is not idle
//    word_done  - one-cycle pulse after the stop bit of the last byte

module unpacker_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 256,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_empty,
   output logic                  word_ren,
   output logic                  tx,
   output logic                  busy,
   output logic                  word_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int NUM_BYTES    = WORD_WIDTH / DATA_WIDTH;

   // Counter widths are kept at least one bit so degenerate parameter
   // choices (one clock per bit, one byte per word) still elaborate.
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (NUM_BYTES > 1)    ? $clog2(NUM_BYTES)    : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1)   ? $clog2(DATA_WIDTH)   : 1;

   localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_STOP   = 3'd5
`ifdef UNPACKER_PARITY_EN
      ,
      S_PARITY = 3'd6
`endif
   } state_t;

   state_t                state;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]      bit_idx;
   logic [BYTE_W-1:0]     byte_idx;
   logic [WORD_WIDTH-1:0] shift_reg;
`ifdef UNPACKER_PARITY_EN
   logic                  parity;
`endif

   // Last clock of the current serial bit.
   logic bit_end;
   assign bit_end = (baud_cnt == LAST_TICK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         word_ren  <= 1'b0;
         busy      <= 1'b0;
         word_done <= 1'b0;
`ifdef UNPACKER_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         // Strobes default low so each is high for exactly one cycle.
         word_ren  <= 1'b0;
         word_done <= 1'b0;

         case (state)
            S_IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (!word_empty) begin
                  state    <= S_FETCH;
                  word_ren <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            // The read strobe is high during this cycle; the FIFO presents
            // the word during LOAD.
            S_FETCH: begin
               state <= S_LOAD;
            end

            S_LOAD: begin
               shift_reg <= word_in;
               byte_idx  <= '0;
               bit_idx   <= '0;
               baud_cnt  <= '0;
               tx        <= 1'b0;
               state     <= S_START;
            end

            S_START: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  bit_idx   <= '0;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
`ifdef UNPACKER_PARITY_EN
                  parity    <= shift_reg[0];
`endif
                  state     <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            // The word shifts right one bit per data bit, so after a full
            // byte the next byte's LSB is already sitting at bit 0.
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
`ifdef UNPACKER_PARITY_EN
                     tx    <= parity;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx   <= bit_idx + BIT_W'(1);
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
`ifdef UNPACKER_PARITY_EN
                     parity    <= parity ^ shift_reg[0];
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

`ifdef UNPACKER_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
`endif

            // Bytes within a word run back to back: STOP feeds START directly.
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_idx != LAST_BYTE) begin
                     byte_idx <= byte_idx + BYTE_W'(1);
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else begin
                     tx        <= 1'b1;
                     busy      <= 1'b0;
                     word_done <= 1'b1;
                     state     <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               baud_cnt <= '0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/unpacker_tx.md
UNPACKER_TX -- requirements
Module: unpacker_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per UART character.
REQ-002 SHALL have parameter WORD_WIDTH, default 256, bits per input word; must be an integer multiple of DATA_WIDTH.
REQ-003 SHALL have parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-004 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port word_in, input, WORD_WIDTH, word from the upstream registered-read FIFO.
REQ-008 SHALL have port word_empty, input, 1, upstream FIFO empty flag.
REQ-009 SHALL have port word_ren, output, 1, one-cycle read strobe to the upstream FIFO.
REQ-010 SHALL have port tx, output, 1, UART serial line, idle high.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port word_done, output, 1, one-cycle pulse when the last byte of a word has been sent.

Function
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division) clk cycles per serial bit, and NUM_BYTES = WORD_WIDTH/DATA_WIDTH.
REQ-014 SHALL implement states IDLE, FETCH, LOAD, START, DATA, STOP, plus PARITY when UNPACKER_PARITY_EN is defined.
REQ-015 IDLE: if word_empty is low, go to FETCH on the next edge; otherwise stay; tx=1.
REQ-016 FETCH: word_ren=1 for exactly this one cycle; go to LOAD.
REQ-017 LOAD: capture word_in into an internal shift register; clear the byte index; go to START.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: send DATA_WIDTH bits, LSB first, CLKS_PER_BIT cycles each; byte 0 = word_in[DATA_WIDTH-1:0] is sent first.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP: if byte index < NUM_BYTES-1, increment the index and go directly to START with no idle gap; otherwise pulse word_done for one cycle and go to IDLE.
REQ-022 tx, word_ren, busy and word_done SHALL be registered outputs; tx first goes low on the cycle after LOAD.
REQ-023 word_empty SHALL be ignored outside IDLE, so at most one word_ren is issued per word.
REQ-024 Back-to-back words: the cycle after word_done, IDLE may go to FETCH, so the inter-word gap is exactly 3 cycles of tx=1.
REQ-025 Baud counter width SHALL be clog2(CLKS_PER_BIT); byte-index width SHALL be clog2(NUM_BYTES) with a minimum of 1.

Reset
REQ-026 While rst is high: state=IDLE, tx=1, word_ren=0, busy=0, word_done=0, and all counters and the shift register = 0.
REQ-027 Reset asserted mid-frame SHALL force tx=1 immediately, without waiting for a clock edge, and abandon the current word without asserting word_done.

Configuration
REQ-028 With macro UNPACKER_PARITY_EN defined, a PARITY state SHALL be inserted between DATA and STOP, driving the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
REQ-029 Without UNPACKER_PARITY_EN, there is no PARITY state and the frame is 10 bits: start, data, stop.

Verification
REQ-030 Reset: assert rst mid-DATA -> tx=1 asynchronously; word_ren, busy and word_done = 0; no word_done after release.
REQ-031 WORD_WIDTH=32, CLKS_PER_BIT=868, word_in=32'hA55A_0F31, one word -> bytes 31,0F,5A,A5 are sent LSB first, each bit held 868 cycles; word_done pulses once, 40*868 cycles after tx first falls.
REQ-032 word_empty held high -> word_ren never asserts; tx stays at 1.
REQ-033 Two words queued (word_empty low throughout) -> exactly two word_ren pulses; 3 idle cycles between the first word's word_done and the second word_ren edge sequence; no ren while busy.
REQ-034 UNPACKER_PARITY_EN defined, byte 8'h07 -> parity bit=1 on tx after bit 7; byte 8'h03 -> parity bit=0; frame length 11*868 cycles.
REQ-035 Default parameters (256-bit word) -> 32 frames with no gap between them; word_done pulses once, 320*868 cycles after tx first falls.
